lcd_bus_driver: RTL and testbench

Hardware HD44780-style LCD write sequencer that sits directly downstream of the CPU's memory-mapped LCD port. It replaces software bit-banging of data, control and enable. The CPU pushes (RS, byte) pairs into a small FIFO. The block drains the FIFO and generates the `lcd_data`/`lcd_ctrl`/`lcd_enable` pin sequence autonomously, including setup, pulse and hold timing and the post-write busy wait. It exposes back-pressure and status so firmware can poll instead of delay-looping.

---
 rtl/lcd_bus_driver.sv | 162 ++++++++++++++++
 tb/tb_lcd_bus_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD write sequencer: a small (RS, byte) FIFO drained by a timed
// SETUP/PULSE/HOLD/WAIT state machine driving the LCD data, control and E pins.
module lcd_bus_driver #(
  parameter int SETUP_CYCLES      = 2,
  parameter int PULSE_CYCLES      = 12,
  parameter int HOLD_CYCLES       = 2,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 80000,
  parameter int FIFO_DEPTH        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_valid,
  input  logic                          wr_rs,
  input  logic [7:0]                    wr_data,
  input  logic                          ovf_clr,
  output logic                          wr_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [7:0]                    lcd_data,
  output logic [1:0]                    lcd_ctrl,
  output logic                          lcd_enable
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int MAX_A = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > CMD_WAIT_CYCLES) ? HOLD_CYCLES : CMD_WAIT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_P = (MAX_C > CLEAR_WAIT_CYCLES) ? MAX_C : CLEAR_WAIT_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [8:0]      mem_q [FIFO_DEPTH];

  logic            push, pop, full, empty, is_clear;
  logic [8:0]      head;

  assign full     = (level_q == LW'(FIFO_DEPTH));
  assign empty    = (level_q == '0);
  assign push     = wr_valid && !full;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign head     = mem_q[rd_ptr_q];
  // Clear/home commands need the long busy wait
  assign is_clear = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    // A dropped push beats a same-cycle clear
    ovf_d = ovf_q;
    if (wr_valid && full) ovf_d = 1'b1;
    else if (ovf_clr)     ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rs_d    = head[8];
          data_d  = head[7:0];
          cnt_d   = CW'(SETUP_CYCLES - 1);
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(PULSE_CYCLES - 1);
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(HOLD_CYCLES - 1);
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cnt_d   = is_clear ? CW'(CLEAR_WAIT_CYCLES - 1) : CW'(CMD_WAIT_CYCLES - 1);
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // E registered so the pin is glitch-free, yet tracks the state exactly
    en_d = (state_d == S_PULSE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_rs, wr_data};
  end

  assign wr_ready   = !full;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign lcd_data   = data_q;
  assign lcd_ctrl   = {rs_q, 1'b0};
  assign lcd_enable = en_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver: reset, single write timing, wait lengths,
// overflow, simultaneous push/pop and mid-transfer reset.
module tb_lcd_bus_driver;
  localparam int SETUP = 2, PULSE = 4, HOLD = 2, CMDW = 10, CLRW = 50, DEPTH = 4;
  localparam int PER_CMD = 1 + SETUP + PULSE + HOLD + CMDW;
  localparam int PER_CLR = 1 + SETUP + PULSE + HOLD + CLRW;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_rs = 1'b0, ovf_clr = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, busy, overflow, lcd_enable;
  logic [2:0] fifo_level;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;

  lcd_bus_driver #(
    .SETUP_CYCLES(SETUP), .PULSE_CYCLES(PULSE), .HOLD_CYCLES(HOLD),
    .CMD_WAIT_CYCLES(CMDW), .CLEAR_WAIT_CYCLES(CLRW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .wr_ready(wr_ready), .busy(busy), .fifo_level(fifo_level),
    .overflow(overflow), .lcd_data(lcd_data), .lcd_ctrl(lcd_ctrl), .lcd_enable(lcd_enable)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every E rising edge with its edge number and {RS, data}
  int         rise_q[$];
  logic [8:0] pdat_q[$];
  logic       prev_en = 1'b0;
  always @(posedge clk) begin
    #2;
    if (lcd_enable && !prev_en) begin
      rise_q.push_back(cyc);
      pdat_q.push_back({lcd_ctrl[1], lcd_data});
    end
    prev_en = lcd_enable;
  end

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic rs, input logic [7:0] d);
    wr_valid = 1'b1; wr_rs = rs; wr_data = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic pair_gap(input logic [7:0] cmd, input int gap);
    int n = 0;
    rise_q.delete(); pdat_q.delete();
    push(1'b0, cmd);
    push(1'b1, 8'h48);
    while (rise_q.size() < 2 && n < 200) begin tick(); n++; end
    check("pair_rises", rise_q.size(), 2);
    if (rise_q.size() >= 2) begin
      check("pair_gap", rise_q[1] - rise_q[0], gap);
      check("pair_d0", pdat_q[0], {1'b0, cmd});
      check("pair_d1", pdat_q[1], 9'h148);
    end
    wait_idle(200);
  endtask

  logic [7:0] ob [6] = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
  int k, n;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_outs", {busy, lcd_enable, overflow, lcd_data, lcd_ctrl, fifo_level}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i % 10 == 0) begin
        check("idle_outs", {busy, lcd_enable, overflow, lcd_data, lcd_ctrl, fifo_level}, 0);
        check("idle_ready", wr_ready, 1);
      end
    end

    // Single data write 0x41
    rise_q.delete(); pdat_q.delete();
    push(1'b1, 8'h41);
    k = cyc;
    check("lvl_after_push", fifo_level, 1);
    check("data_before_latch", lcd_data, 8'h00);
    tick();
    check("data_latch", lcd_data, 8'h41);
    check("ctrl_latch", lcd_ctrl, 2'b10);
    check("lvl_after_pop", fifo_level, 0);
    for (int c = k + 2; c <= k + 20; c++) begin
      tick();
      check("e_window", lcd_enable, (c >= k + 3 && c < k + 7) ? 1 : 0);
      check("busy_window", busy, (c < k + 19) ? 1 : 0);
    end
    check("data_held", lcd_data, 8'h41);

    // Clear-class command vs normal command spacing
    pair_gap(8'h01, PER_CLR);
    pair_gap(8'h38, PER_CMD);

    // Overflow: six back-to-back pushes from idle
    rise_q.delete(); pdat_q.delete();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_rs = 1'b1; wr_data = ob[i];
      tick();
      if (i == 3) check("ready_before_full", wr_ready, 1);
      if (i == 4) begin
        check("ready_full", wr_ready, 0);
        check("lvl_full", fifo_level, 4);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 5) begin
        check("ovf_set", overflow, 1);
        check("lvl_kept", fifo_level, 4);
      end
    end
    wr_valid = 1'b0;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_idle(300);
    check("ovf_pulses", rise_q.size(), 5);
    if (rise_q.size() == 5)
      for (int i = 0; i < 5; i++) check("ovf_order", pdat_q[i], {1'b1, ob[i]});

    // Push in the same cycle IDLE pops with level 2
    push(1'b1, 8'hA1);
    k = cyc;
    tick();
    push(1'b1, 8'hB2);
    push(1'b1, 8'hC3);
    check("pp_lvl_pre", fifo_level, 2);
    n = 0;
    while (cyc < k + PER_CMD && n < 100) begin tick(); n++; end
    check("pp_lvl_idle", fifo_level, 2);
    push(1'b1, 8'hD4);
    check("pp_lvl_same", fifo_level, 2);
    check("pp_popped", lcd_data, 8'hB2);
    wait_idle(200);

    // Reset while E is high
    push(1'b1, 8'h55);
    push(1'b1, 8'h66);
    n = 0;
    while (!lcd_enable && n < 50) begin tick(); n++; end
    check("e_before_rst", lcd_enable, 1);
    rst_n = 1'b0;
    #1;
    check("rst_e", lcd_enable, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_lvl", fifo_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rise_q.delete();
    repeat (40) tick();
    check("no_stale_pulse", rise_q.size(), 0);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
